mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port clk SHALL be an input, 1 bit wide, used as the system clock, with all state updated on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-004 The port start SHALL be an input, 1 bit wide: E-stage qualifier, meaning mdu_op is valid this cycle.
REQ-005 The port mdu_op SHALL be an input, 3 bits wide: operation code (MULT, MULTU, DIV, DIVU, MTHI, MTLO); other codes mean no operation.
REQ-006 The port A SHALL be an input, 32 bits wide: rs operand (E-stage forwarded value).
REQ-007 The port B SHALL be an input, 32 bits wide: rt operand (E-stage forwarded value).
REQ-008 The port busy SHALL be an output, 1 bit wide: an operation is in flight; the stall logic treats start|busy as a hazard for any D-stage mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 The port HI SHALL be an output, 32 bits wide: architectural HI register.
REQ-010 The port LO SHALL be an output, 32 bits wide: architectural LO register.

Function
REQ-011 The block SHALL use the states IDLE and BUSY; busy SHALL equal (state==BUSY), registered, with no combinational path from start.
REQ-012 In IDLE, start with MULT/MULTU SHALL latch the 64-bit product {hi,lo} into temp registers, load count=5 and go to BUSY.
REQ-013 In IDLE, start with DIV/DIVU SHALL latch the quotient into temp-LO and the remainder into temp-HI, load count=10 and go to BUSY.
REQ-014 MULT and DIV SHALL treat A and B as signed; MULTU and DIVU SHALL treat them as unsigned.
REQ-015 Signed quotients SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-016 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-017 Division by zero SHALL still run 10 busy cycles and SHALL leave HI/LO unchanged at completion.
REQ-018 In BUSY, count SHALL decrement every cycle; on the edge where count==1, temp SHALL be written to HI/LO, count SHALL go to 0 and the state SHALL return to IDLE.
REQ-019 Latency: for start sampled at edge k, busy SHALL be high for cycles k+1..k+N (N=5 or 10), and new HI/LO SHALL be visible from cycle k+N+1 with busy low in the same cycle.
REQ-020 MTHI/MTLO with start in IDLE SHALL write A to HI/LO at the same edge, with no busy cycle.
REQ-021 start while BUSY (any op) SHALL be ignored: no state, temp or HI/LO change.
REQ-022 HI/LO SHALL hold their old values throughout BUSY until the completion edge.
REQ-023 start with a no-operation code SHALL be ignored.
REQ-024 A back-to-back start in the cycle after the completion edge (IDLE) SHALL be accepted normally.

Reset
REQ-025 Asynchronous reset assertion SHALL immediately force state=IDLE, busy=0, count=0, HI=0, LO=0 and temp=0.
REQ-026 Reset mid-operation SHALL abort the operation, and its result SHALL never be written.
REQ-027 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the mdu_op codes (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5), the latency constants MUL_CYCLES=5 and DIV_CYCLES=10, and the state encoding.
REQ-029 The count register SHALL be 4 bits wide.
REQ-030 The block SHALL be a single module with no sub-module; the decode producing start/mdu_op SHALL stay in the existing control decoder.

Verification
REQ-031 Bench scenario: MULT A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-032 Bench scenario: DIVU A=100, B=7, then DIV A=0xFFFFFF9C (-100), B=7 -> first LO=14, HI=2, each after 10 busy cycles; then LO=0xFFFFFFF2, HI=0xFFFFFFFE.
REQ-033 Bench scenario: DIV by zero after MTHI A=0x1234 and MTLO A=0x5678 -> 10 busy cycles, then HI=0x1234 and LO=0x5678 unchanged.
REQ-034 Bench scenario: MULTU 0xFFFFFFFF*0xFFFFFFFF, then start MTHI on busy cycle 2 -> MTHI ignored; final HI=0xFFFFFFFE and LO=0x00000001.
REQ-035 Bench scenario: DIV started, reset pulsed in busy cycle 4 -> immediately busy=0 and HI=LO=0; no late write occurs.
REQ-036 Bench scenario: MULT completes and MULTU 2*3 is started in the next idle cycle -> accepted; busy low for exactly one cycle in between; then LO=6.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit:
//   - mdu_op operation codes as seen on the mdu.mdu_op port
//   - busy latencies for multiply and divide
//   - FSM state encoding
//   - small two's-complement helpers used by the divider datapath
// -----------------------------------------------------------------------------
package mdu_pkg;

  // Operation codes; 3'd6 and 3'd7 are no-operation.
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Number of cycles busy stays high after an accepted start.
  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // HI/LO pair carried through the temp registers.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  // Magnitude of a 32-bit value, interpreted as signed when is_signed is set.
  // The magnitude of 0x80000000 is 0x80000000 as an unsigned number.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = (~v) + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Conditional two's-complement negation.
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = (~v) + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result of MULT/MULTU/DIV/DIVU is computed when the op is accepted and
// parked in temp registers; it is copied to HI/LO after the fixed busy
// latency (MUL_CYCLES or DIV_CYCLES). MTHI/MTLO write HI/LO immediately.
// Starts arriving while busy, and no-operation codes, are ignored.
//
// Ports:
//   clk     in   1  system clock, rising edge
//   reset   in   1  asynchronous active-high reset
//   start   in   1  mdu_op is valid this cycle
//   mdu_op  in   3  operation code (see mdu_pkg)
//   A       in  32  rs operand
//   B       in  32  rt operand
//   busy    out  1  operation in flight (registered)
//   HI      out 32  architectural HI
//   LO      out 32  architectural LO
// -----------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e      state_q;
  logic        busy_q;
  logic [3:0]  count_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  hilo_t       temp_q;

  logic        is_signed_s;
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] mul_prod_s;
  logic [31:0] div_a_mag_s;
  logic [31:0] div_b_mag_s;
  logic [31:0] quo_mag_s;
  logic [31:0] rem_mag_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        div_zero_s;
  hilo_t       temp_d;

  // Signedness of the current op: only MULT and DIV are signed.
  always_comb begin
    if ((mdu_op == OP_MULT) || (mdu_op == OP_DIV)) begin
      is_signed_s = 1'b1;
    end else begin
      is_signed_s = 1'b0;
    end
  end

  // 64-bit product: sign- or zero-extend both operands, keep the low 64 bits.
  always_comb begin
    mul_a_s    = {{32{is_signed_s & A[31]}}, A};
    mul_b_s    = {{32{is_signed_s & B[31]}}, B};
    mul_prod_s = mul_a_s * mul_b_s;
  end

  // Divide on magnitudes, then fix signs: quotient negative when operand
  // signs differ (truncation toward zero), remainder follows the dividend.
  // 0x80000000 / -1 falls out as 0x80000000 remainder 0 without a special case.
  always_comb begin
    div_zero_s  = (B == 32'd0);
    div_a_mag_s = mag32(A, is_signed_s);
    div_b_mag_s = mag32(B, is_signed_s);
    if (div_zero_s) begin
      quo_mag_s = 32'd0;
      rem_mag_s = 32'd0;
    end else begin
      quo_mag_s = div_a_mag_s / div_b_mag_s;
      rem_mag_s = div_a_mag_s % div_b_mag_s;
    end
    quo_s = neg_if(quo_mag_s, is_signed_s & (A[31] ^ B[31]));
    rem_s = neg_if(rem_mag_s, is_signed_s & A[31]);
  end

  // Value to park in temp for an accepted multiply/divide. A divide by zero
  // parks the current HI/LO so the completion write leaves them unchanged.
  always_comb begin
    temp_d = temp_q;
    case (mdu_op)
      OP_MULT, OP_MULTU: begin
        temp_d.hi = mul_prod_s[63:32];
        temp_d.lo = mul_prod_s[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (div_zero_s) begin
          temp_d.hi = hi_q;
          temp_d.lo = lo_q;
        end else begin
          temp_d.hi = rem_s;
          temp_d.lo = quo_s;
        end
      end
      default: begin
        temp_d = temp_q;
      end
    endcase
  end

  // Control FSM, countdown, temp capture and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      count_q <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      temp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT, OP_MULTU: begin
                temp_q  <= temp_d;
                count_q <= MUL_CYCLES;
                state_q <= BUSY;
                busy_q  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                temp_q  <= temp_d;
                count_q <= DIV_CYCLES;
                state_q <= BUSY;
                busy_q  <= 1'b1;
              end
              OP_MTHI: begin
                hi_q <= A;
              end
              OP_MTLO: begin
                lo_q <= A;
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end
        end
        BUSY: begin
          // count==1 marks the last busy cycle: commit on this edge.
          if (count_q == 4'd1) begin
            hi_q    <= temp_q.hi;
            lo_q    <= temp_q.lo;
            count_q <= 4'd0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= 4'd0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu
// Scoreboard bench for mdu. The driver issues ops and, for every op the
// reference model says is accepted (or a no-op issued while idle), pushes the
// expected HI/LO, the edge at which they must first be visible and the busy
// length. A monitor on the falling edge pops each entry when it falls due and
// also flags any busy fall-off that was not expected.
// -----------------------------------------------------------------------------
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter: the value seen after an edge is that edge's number.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          due;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: architectural HI/LO after all accepted ops, and the
  // first edge at which a new start is accepted.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          free_edge;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural effect of one accepted op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sbv, q, r;
    logic [63:0] res;
    longint unsigned ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (op)
      3'd0: res = sa * sbv;
      3'd1: res = ua * ub;
      3'd2: begin
        if (b == 32'd0) res = {hi, lo};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {hi, lo};
        else res = {a % b, a / b};
      end
      3'd4: res = {a, lo};
      3'd5: res = {hi, a};
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return 5;
    if (op == 3'd2 || op == 3'd3) return 10;
    return 0;
  endfunction

  // Drive one op for one cycle. Called just after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [31:0] ehi, input logic [31:0] elo);
    int e;
    int n;
    logic [63:0] r;
    exp_t it;
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    e      = cyc + 1;
    if (e >= free_edge) begin
      r = model(op, a, b, m_hi, m_lo);
      if (use_exp) r = {ehi, elo};
      n = latency(op);
      it.due = e + n;
      it.n   = n;
      it.hi  = r[63:32];
      it.lo  = r[31:0];
      sb.push_back(it);
      m_hi = r[63:32];
      m_lo = r[31:0];
      free_edge = e + n + 1;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 3'($urandom_range(0, 7));
    A      = $urandom;
    B      = $urandom;
  endtask

  task automatic iss(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic iss_x(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    issue(op, a, b, 1'b1, ehi, elo);
  endtask

  // Advance so that the next issue is sampled on the first accepting edge.
  task automatic wait_free();
    while (cyc + 1 < free_edge) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: track busy runs and pop scoreboard entries as they fall due.
  int   run = 0;
  int   last_run = 0;
  bit   fell = 1'b0;
  exp_t item;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      last_run = 0;
      fell = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        last_run = run;
        run = 0;
        fell = 1'b1;
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        item = sb.pop_front();
        chk("missed_completion_edge", 32'(cyc), 32'(item.due));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        item = sb.pop_front();
        chk("HI", HI, item.hi);
        chk("LO", LO, item.lo);
        chk("busy_at_result", {31'd0, busy}, 32'd0);
        if (item.n > 0) chk("busy_cycles", 32'(last_run), 32'(item.n));
        last_run = 0;
        fell = 1'b0;
      end else if (fell) begin
        chk("unexpected_completion_cycle", 32'(cyc), 32'(-1));
        fell = 1'b0;
      end
    end
  end

  logic [31:0] ra, rb;
  int          sel;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    mdu_op = 3'd7;
    A      = 32'd0;
    B      = 32'd0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    free_edge = 0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Signed multiply, started on the first edge after reset release.
    iss_x(3'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);

    // Unsigned then signed divide.
    wait_free();
    iss_x(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_free();
    iss_x(3'd2, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2);

    // MTHI/MTLO then divide by zero leaves HI/LO alone.
    wait_free();
    iss_x(3'd4, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFF2);
    iss_x(3'd5, 32'h5678, 32'd0, 32'h1234, 32'h5678);
    iss_x(3'd2, 32'd55, 32'd0, 32'h1234, 32'h5678);

    // Signed overflow corner.
    wait_free();
    iss_x(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // No-op in idle leaves everything unchanged.
    wait_free();
    iss_x(3'd7, 32'hAAAA5555, 32'h1, 32'h0, 32'h80000000);

    // MULTU max, MTHI during busy cycle 2 is ignored.
    wait_free();
    iss_x(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(posedge clk);
    #1;
    iss(3'd4, 32'hDEADBEEF, 32'd0);

    // Reset in busy cycle 4 of a divide aborts it.
    wait_free();
    iss(3'd2, 32'd100, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    sb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    free_edge = 0;
    #1;
    chk("midop_reset_busy", {31'd0, busy}, 32'd0);
    chk("midop_reset_HI", HI, 32'd0);
    chk("midop_reset_LO", LO, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    iss_x(3'd6, 32'h1, 32'h2, 32'h0, 32'h0);

    // Back-to-back: MULT completes, MULTU accepted on the very next edge.
    wait_free();
    iss_x(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_free();
    iss_x(3'd1, 32'd2, 32'd3, 32'd0, 32'd6);

    // Random ops with random gaps; starts during busy are ignored by the model.
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        2: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      sel = $urandom_range(0, 6);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      iss(3'($urandom_range(0, 7)), ra, rb);
      repeat ($urandom_range(0, 11)) begin
        @(posedge clk);
        #1;
      end
    end

    // Drain with a bounded wait.
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
